// File: rtl/decoder_n_seq.sv
// decoder_n_seq: registered N-to-2^N one-hot decoder with valid/ready load port and optional scan sequencer.
// Ports: clk, rst_n (async active-low), en, mode, in_valid/in_ready/in (select load),
//        out (one-hot), out_valid, idx (binary index of out), scan_wrap (pulse on scan wrap).
// Define DEC_SCAN_EN to compile in the SCAN state, dwell counter and wrap logic.
module decoder_n_seq #(
  parameter int IN_W  = 3,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in,
  output logic [(1<<IN_W)-1:0] out,
  output logic                 out_valid,
  output logic [IN_W-1:0]      idx,
  output logic                 scan_wrap
);
  localparam int OUT_W = 1 << IN_W;
`ifdef DEC_SCAN_EN
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
  logic [15:0] cnt, cnt_n;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
  logic unused_cfg;
  assign unused_cfg = mode ^ (DWELL == 0);
`endif
  state_t state, state_n;
  logic [OUT_W-1:0] out_n;
  logic [IN_W-1:0] idx_n;
  logic valid_n, wrap_n;
`ifdef DEC_SCAN_EN
  assign in_ready = rst_n & en & ~mode & (state != SCAN);
`else
  assign in_ready = rst_n & en;
`endif
  always_comb begin
    state_n = state;
    out_n   = out;
    idx_n   = idx;
    valid_n = out_valid;
    wrap_n  = 1'b0;
`ifdef DEC_SCAN_EN
    cnt_n   = cnt;
`endif
    if (!en) begin
      state_n = IDLE;
      out_n   = '0;
      idx_n   = '0;
      valid_n = 1'b0;
`ifdef DEC_SCAN_EN
      cnt_n   = '0;
`endif
    end
`ifdef DEC_SCAN_EN
    else if (state == SCAN) begin
      if (!mode) begin
        state_n = IDLE;
        out_n   = '0;
        idx_n   = '0;
        valid_n = 1'b0;
        cnt_n   = '0;
      end else if (cnt == 16'(DWELL - 1)) begin
        cnt_n  = '0;
        idx_n  = idx + 1'b1;
        out_n  = (out << 1) | (out >> (OUT_W - 1));
        wrap_n = (idx == IN_W'(OUT_W - 1));
      end else begin
        cnt_n = cnt + 16'd1;
      end
    end else if (mode) begin
      state_n = SCAN;
      out_n   = OUT_W'(1);
      idx_n   = '0;
      valid_n = 1'b1;
      cnt_n   = '0;
    end
`endif
    else if (in_valid && in_ready) begin
      state_n = HOLD;
      out_n   = OUT_W'(1) << in;
      idx_n   = in;
      valid_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
`ifdef DEC_SCAN_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_n;
      out       <= out_n;
      idx       <= idx_n;
      out_valid <= valid_n;
      scan_wrap <= wrap_n;
`ifdef DEC_SCAN_EN
      cnt       <= cnt_n;
`endif
    end
  end
endmodule

// File: tb/tb_decoder_n_seq.sv
// tb_decoder_n_seq: scoreboard bench for decoder_n_seq (directed vectors, queue-based monitor).
module tb_decoder_n_seq;
  localparam int IW = 3;
  localparam int OW = 8;
  localparam int DW = 3;
  typedef struct packed {
    logic [OW-1:0] o;
    logic [IW-1:0] i;
    logic          v;
    logic          w;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic [IW-1:0] in_s = '0;
  logic in_ready, out_valid, scan_wrap;
  logic [OW-1:0] out;
  logic [IW-1:0] idx;
  exp_t q[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  decoder_n_seq #(.IN_W(IW), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in(in_s), .out(out), .out_valid(out_valid),
    .idx(idx), .scan_wrap(scan_wrap)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t mk(input int o, input int i, input bit v, input bit w);
    exp_t r;
    r.o = OW'(o);
    r.i = IW'(i);
    r.v = v;
    r.w = w;
    return r;
  endfunction
  task automatic drive(input logic e_i, input logic m_i, input logic v_i, input int s, input exp_t x);
    @(negedge clk);
    en = e_i;
    mode = m_i;
    in_valid = v_i;
    in_s = IW'(s);
    q.push_back(x);
  endtask
  task automatic async_rst_check;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_idx", idx, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_wrap", scan_wrap, 0);
    @(negedge clk) rst_n = 1'b1;
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out", out, e.o);
      chk("idx", idx, e.i);
      chk("out_valid", out_valid, e.v);
      chk("scan_wrap", scan_wrap, e.w);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_out", out, 0);
    chk("rst_idx", idx, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_wrap", scan_wrap, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < OW; i++) begin
      drive(1, 0, 1, i, mk(1 << i, i, 1, 0));
      #1 chk("sweep_in_ready", in_ready, 1);
    end
    drive(1, 0, 0, 0, mk(8'h80, 7, 1, 0));
    drive(1, 0, 0, 3, mk(8'h80, 7, 1, 0));
    drive(0, 0, 1, 5, mk(0, 0, 0, 0));
    #1 chk("en_prio_in_ready", in_ready, 0);
    drive(1, 0, 1, 2, mk(8'h04, 2, 1, 0));
    drive(1, 0, 1, 5, mk(8'h20, 5, 1, 0));
    @(negedge clk) in_valid = 1'b0;
    async_rst_check();
`ifdef DEC_SCAN_EN
    drive(1, 1, 0, 0, mk(1, 0, 1, 0));
    #1 chk("scan_in_ready", in_ready, 0);
    for (int k = 1; k <= 30; k++)
      drive(1, 1, 0, 0, mk(1 << ((k / DW) % OW), (k / DW) % OW, 1, k == OW * DW));
    drive(1, 0, 0, 0, mk(0, 0, 0, 0));
    #1 chk("exit_in_ready", in_ready, 0);
    drive(1, 0, 1, 1, mk(8'h02, 1, 1, 0));
    drive(1, 1, 0, 0, mk(1, 0, 1, 0));
    for (int k = 1; k <= 9; k++)
      drive(1, 1, 0, 0, mk(1 << (k / DW), k / DW, 1, 0));
    @(negedge clk) mode = 1'b1;
    async_rst_check();
    mode = 1'b0;
`else
    drive(1, 1, 1, 6, mk(8'h40, 6, 1, 0));
    #1 chk("modeoff_in_ready", in_ready, 1);
    drive(1, 1, 0, 0, mk(8'h40, 6, 1, 0));
    drive(1, 1, 0, 0, mk(8'h40, 6, 1, 0));
`endif
    drive(0, 0, 0, 0, mk(0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decoder_n_seq.md
# decoder_n_seq

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready load port and an optional autonomous scan mode. It generalises the team's fixed 3-to-8 combinational decoder. Typical uses are channel-select, row-strobe and LED/mux drive logic. It also works as a self-timed one-hot sequencer when no upstream source is present.

## Interface
- IN_W, 3, select width; legal 1..6; output width OUT_W = 2^IN_W (localparam)
- DWELL, 4, cycles each one-hot position is held in scan mode; legal 1..65535
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; 0 forces IDLE
- mode  input  1  0 = direct decode, 1 = scan (scan only with DEC_SCAN_EN)
- in_valid  input  1  select word valid
- in_ready  output  1  block accepts select word this cycle
- in  input  IN_W  select word
- out  output  OUT_W  registered one-hot output (all-zero when inactive)
- out_valid  output  1  out holds a meaningful one-hot value
- idx  output  IN_W  binary index of the currently asserted bit
- scan_wrap  output  1  one-cycle pulse when scan wraps from last index to 0

## Operation
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out=0, out_valid=0, idx=0, scan_wrap=0, state=IDLE. in_ready=0 while rst_n=0.
- States:
  - IDLE: out=0, out_valid=0.
  - HOLD: direct value held.
  - SCAN: autonomous stepping.
- in_ready is combinational: en & ~mode & (state != SCAN).
- Direct accept: in_valid & in_ready at a rising edge → out <= 1<<in, idx <= in, out_valid <= 1, state → HOLD.
- HOLD keeps out until the next accept, en=0, or a mode change.
- Back-to-back accepts are allowed every cycle.
- en=0 at an edge → IDLE, out=0, out_valid=0, dwell counter cleared, idx=0. This has priority over every other event, including a simultaneous in_valid; no accept occurs.
- en=1 & mode=1 from IDLE or HOLD → SCAN, with idx=0, out=1, out_valid=1, dwell counter=0.
- SCAN stepping:
  - The dwell counter increments each cycle.
  - When it reaches DWELL-1: counter → 0, idx → idx+1, out rotates left by one.
- Wrap: at idx = OUT_W-1, the step goes to idx=0, out=1, and scan_wrap=1 for exactly that one cycle.
- mode 1→0 while in SCAN → IDLE next edge (out=0). The block does not resume a held value.
- out is always one-hot or all-zero; no other encoding is legal.
- idx and out always agree: out == 1<<idx whenever out_valid=1.
- Reset asserted mid-scan or mid-hold clears everything asynchronously. After release the block restarts from IDLE.

## Timing
- Direct decode latency: 1 cycle from the accepting edge to out.
- Scan entry: out=1 from the first edge at which en & mode are seen high in IDLE/HOLD.
- Each scan position lasts exactly DWELL cycles. A full period is OUT_W·DWELL cycles.
- DWELL=1: idx advances every cycle. scan_wrap pulses every OUT_W cycles.
- scan_wrap is registered and coincident with the cycle where idx=0 after a wrap. It is never asserted on scan entry.
- All outputs except in_ready are registered.

## Configuration
- DEC_SCAN_EN defined:
  - The SCAN state, dwell counter and wrap logic are compiled in.
  - mode behaves as above.
- DEC_SCAN_EN undefined:
  - No SCAN state or dwell counter exists. DWELL is ignored.
  - mode is ignored and treated as 0; in_ready = en.
  - scan_wrap is tied to 0.
  - Direct decode behaviour is unchanged.

## Test plan
- Reset/direct sweep:
  - IN_W=3. Assert rst_n low, then release.
  - With en=1, mode=0, drive in=0..7 with in_valid=1 on consecutive cycles.
  - Each edge+1: out = 00000001, 00000010 … 10000000, idx matches, out_valid=1.
- Enable priority: en=0 with in_valid=1 and in=5 in the same cycle → out=0, out_valid=0, in_ready=0, no accept.
- Scan wrap (DEC_SCAN_EN, IN_W=2, DWELL=3):
  - mode=1, en=1 → out 0001,0010,0100,1000, each held 3 cycles.
  - Then 0001 with scan_wrap=1 for one cycle, 12 cycles after entry.
- Scan exit: mode 1→0 mid-scan while idx=2 → next edge out=0, out_valid=0. A following in_valid with in=1 is accepted, giving out=0010.
- Async reset mid-scan: pulse rst_n low between edges with idx=3 → out=0, idx=0, scan_wrap=0 immediately, without waiting for clk.
- Macro off (DEC_SCAN_EN undefined): mode=1, en=1, in_valid=1, in=6 → in_ready=1, out=01000000, scan_wrap stays 0.
